// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard/sequencing controller for a 5-stage RISC-V pipeline.
//                Handles load-use stalls, MEM-resolved branch flushes and
//                data-memory req/ack waits with a timeout into a sticky ERR.
//                Optional performance counters: define HAZ_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_en,
  output logic        pc_src,
  output logic        ifid_en,
  output logic        pipe_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  logic w_active;
  logic w_req;
  logic w_stall;
  logic w_branch;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_load_use;

  // Gating with rst_n keeps every output low for the whole reset window.
  assign w_active   = rst_n && (r_state != S_ERR);
  assign w_req      = w_active && (mem_memread || mem_memwrite);
  assign w_stall    = w_req && !dmem_ack;
  assign w_branch   = mem_branch && mem_zero;
  assign w_hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
  assign w_load_use = ex_memread && (ex_rd != 5'd0) && (w_hit_rs1 || w_hit_rs2);

  assign dmem_req = w_req;
  assign mem_err  = rst_n && (r_state == S_ERR);

  always_comb begin
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    ifid_en     = 1'b0;
    pipe_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (w_active) begin
      if (w_stall) begin
        // Memory wait freezes the whole pipeline, nothing else may act.
        pc_en = 1'b0;
      end else if (w_branch) begin
        pc_src      = 1'b1;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pipe_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_load_use) begin
        pipe_en    = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        pipe_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_stall) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        S_MEM_WAIT: begin
          if (!w_stall) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == C_TIMEOUT) begin
            r_state <= S_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_flush_evt;

  assign w_flush_evt = w_active && !w_stall && w_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_active && !pc_en && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread;
  logic       mem_branch, mem_zero, mem_memread, mem_memwrite, dmem_ack;
  logic       dmem_req, pc_en, pc_src, ifid_en, pipe_en;
  logic       ifid_flush, idex_flush, exmem_flush, mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .pc_src(pc_src), .ifid_en(ifid_en),
    .pipe_en(pipe_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {dmem_req, pc_en, pc_src, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush, mem_err}
  localparam logic [8:0] ZERO   = 9'b0_0_0_0_0_000_0;
  localparam logic [8:0] IDLE   = 9'b0_1_0_1_1_000_0;
  localparam logic [8:0] LU     = 9'b0_0_0_0_1_010_0;
  localparam logic [8:0] BR     = 9'b0_1_1_1_1_111_0;
  localparam logic [8:0] BR_ACK = 9'b1_1_1_1_1_111_0;
  localparam logic [8:0] MSTALL = 9'b1_0_0_0_0_000_0;
  localparam logic [8:0] MACK   = 9'b1_1_0_1_1_000_0;
  localparam logic [8:0] ERR    = 9'b0_0_0_0_0_000_1;

  logic [8:0] obs;
  assign obs = {dmem_req, pc_en, pc_src, ifid_en, pipe_en,
                ifid_flush, idex_flush, exmem_flush, mem_err};

  string      sb_tag[$];
  logic [8:0] sb_exp[$];
  int         total = 0;
  int         bad   = 0;

  task automatic check();
    string      tag;
    logic [8:0] exp;
    total++;
    if (sb_exp.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %b want an entry", obs);
      return;
    end
    tag = sb_tag.pop_front();
    exp = sb_exp.pop_front();
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [8:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic async_check(input string tag, input logic [8:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
    #1;
    check();
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_lu_rs1();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk); #1;
    // Inputs that would stall/branch must still be masked during reset.
    set_lu_rs1(); mem_memread = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    step("reset_state", ZERO);
    clr();
    rst_n = 1'b1;
    step("idle", IDLE);

    set_lu_rs1();                            step("load_use_rs1", LU);
    ex_memread = 1'b0;                       step("after_bubble", IDLE);
    set_lu_rs1(); ex_rd = 5'd0; id_rs1 = 5'd0; step("load_use_x0", IDLE);
    clr(); ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
                                             step("load_use_rs2", LU);
    id_use_rs2 = 1'b0;                       step("unused_rs2", IDLE);
    id_use_rs2 = 1'b1; ex_memread = 1'b0;    step("no_load", IDLE);
    clr(); set_lu_rs1(); mem_branch = 1'b1; mem_zero = 1'b1;
                                             step("branch_over_lu", BR);
    mem_zero = 1'b0;                         step("branch_not_taken", LU);

    clr(); mem_memread = 1'b1;
    step("mem_wait_1", MSTALL);
    step("mem_wait_2", MSTALL);
    step("mem_wait_3", MSTALL);
    dmem_ack = 1'b1;                         step("mem_ack", MACK);
    clr();                                   step("mem_done", IDLE);
    mem_memwrite = 1'b1; dmem_ack = 1'b1;    step("zero_wait", MACK);

    clr(); mem_memread = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1; set_lu_rs1();
                                             step("branch_in_stall", MSTALL);
    dmem_ack = 1'b1;                         step("branch_on_ack", BR_ACK);

    // One RUN stall cycle then four MEM_WAIT cycles before ERR.
    clr(); mem_memwrite = 1'b1;
    for (int i = 0; i < 5; i++) step($sformatf("timeout_wait_%0d", i), MSTALL);
    step("err_entry", ERR);
    dmem_ack = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    step("err_sticky", ERR);
    #2 rst_n = 1'b0;
    async_check("err_reset", ZERO);
    @(posedge clk); #1;
    rst_n = 1'b1; clr();
    step("err_cleared", IDLE);

    mem_memread = 1'b1;
    step("rst_wait_1", MSTALL);
    step("rst_wait_2", MSTALL);
    #2 rst_n = 1'b0;
    async_check("reset_mid_wait", ZERO);
    @(posedge clk); #1;
    rst_n = 1'b1; clr();
    step("post_reset_idle", IDLE);
    mem_memread = 1'b1; dmem_ack = 1'b1;
    step("post_reset_zero_wait", MACK);
    clr();

`ifdef HAZ_PERF_CNT_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_lu_rs1(); step("perf_lu_1", LU);
    clr();        step("perf_gap", IDLE);
    set_lu_rs1(); step("perf_lu_2", LU);
    clr(); mem_branch = 1'b1; mem_zero = 1'b1; step("perf_branch", BR);
    clr();
    total++;
    assert (stall_cnt === 32'd2) else begin
      bad++;
      $error("FAIL stall_cnt: got %0d want 2", stall_cnt);
    end
    total++;
    assert (flush_cnt === 32'd1) else begin
      bad++;
      $error("FAIL flush_cnt: got %0d want 1", flush_cnt);
    end
`endif

    total++;
    assert (sb_exp.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: got %0d left want 0", sb_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
